// File: rtl/aram_sp_arbiter.sv
// Round-robin two-client arbiter/sequencer for an async single-port RAM.
// Ports: clk, rst_n; req/we/addr/wdata in and ack/err/rdata out per client; busy; ram_address/ram_wr_rd_en/ram_data to RAM.
module aram_sp_arbiter #(
  parameter int data_width    = 8,
  parameter int address_width = 4,
  parameter int RAM_size      = 16,
  parameter int WR_CYCLES     = 2,
  parameter int RD_CYCLES     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [address_width-1:0] addr0,
  input  logic [address_width-1:0] addr1,
  input  logic [data_width-1:0]    wdata0,
  input  logic [data_width-1:0]    wdata1,
  output logic                     ack0,
  output logic                     ack1,
  output logic                     err0,
  output logic                     err1,
  output logic [data_width-1:0]    rdata0,
  output logic [data_width-1:0]    rdata1,
  output logic                     busy,
  output logic [address_width-1:0] ram_address,
  output logic                     ram_wr_rd_en,
  inout  wire  [data_width-1:0]    ram_data
);

  typedef enum logic [2:0] {
    IDLE, SETUP, WRITE, HOLD, READ, ACK
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     gnt_q, gnt_d;
  logic                     last_q, last_d;
  logic                     we_q, we_d;
  logic                     err_q, err_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]    wdata_q, wdata_d;

  logic                     ack0_q, ack1_q;
  logic                     err0_q, err1_q;
  logic [data_width-1:0]    rdata0_q, rdata1_q;
  logic                     busy_q, wr_q, drv_q;
  logic [address_width-1:0] ram_addr_q;

  logic                     pick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // Tie goes to the client that did not win last time.
    pick    = (req0 && req1) ? ~last_q : req1;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = pick;
          last_d  = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          if (32'(addr_d) >= RAM_size) begin
            err_d   = 1'b1;
            state_d = ACK;
          end else begin
            err_d   = 1'b0;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = we_q ? WRITE : READ;
      end
      WRITE: begin
        if (cnt_q == 8'(WR_CYCLES - 1)) state_d = HOLD;
        else cnt_d = cnt_q + 8'd1;
      end
      HOLD: state_d = ACK;
      READ: begin
        if (cnt_q == 8'(RD_CYCLES - 1)) state_d = ACK;
        else cnt_d = cnt_q + 8'd1;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
      drv_q      <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      // Outputs are registered from the next state so they line up with it.
      busy_q  <= (state_d != IDLE);
      wr_q    <= (state_d == WRITE);
      drv_q   <= (state_d == WRITE) || (state_d == HOLD);
      ack0_q  <= (state_d == ACK) && !gnt_d;
      ack1_q  <= (state_d == ACK) && gnt_d;
      err0_q  <= (state_d == ACK) && !gnt_d && err_d;
      err1_q  <= (state_d == ACK) && gnt_d && err_d;
      if (state_q == IDLE && state_d == SETUP)
        ram_addr_q <= addr_d;
      if (state_q == READ && state_d == ACK) begin
        if (gnt_q) rdata1_q <= ram_data;
        else       rdata0_q <= ram_data;
      end
    end
  end

  assign ram_data     = drv_q ? wdata_q : {data_width{1'bz}};
  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign err0         = err0_q;
  assign err1         = err1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign busy         = busy_q;
  assign ram_address  = ram_addr_q;
  assign ram_wr_rd_en = wr_q;

endmodule

// File: tb/tb_aram_sp_arbiter.sv
// Bench for aram_sp_arbiter: vector table of client transactions
// against a behavioural async RAM, plus reset and fairness sequences.
module tb_aram_sp_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [3:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       ack0, ack1, err0, err1, busy;
  logic [7:0] rdata0, rdata1;
  logic [3:0] ram_address;
  logic       ram_wr_rd_en;
  wire  [7:0] ram_data;

  logic [7:0] mem [16];
  logic       rd_phase = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aram_sp_arbiter #(
    .data_width(8), .address_width(4), .RAM_size(12),
    .WR_CYCLES(2), .RD_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_address(ram_address), .ram_wr_rd_en(ram_wr_rd_en),
    .ram_data(ram_data)
  );

  // Behavioural RAM: drives only while the bench expects a read.
  assign ram_data = (rd_phase && !ram_wr_rd_en) ?
                    mem[ram_address] : 8'bz;

  always @(posedge clk)
    if (ram_wr_rd_en) mem[ram_address] <= ram_data;

  typedef struct {
    logic       c;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wd;
    int         lat;
    logic       err;
    logic [7:0] rd;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int  k, wrc, drc, hdc;
    bit  started, got, pb, other;
    @(negedge clk);
    rd_phase = !v.we;
    if (v.c) begin
      req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wd;
    end else begin
      req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wd;
    end
    k = 0; wrc = 0; drc = 0; hdc = 0;
    started = 0; got = 0; other = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      pb = busy;
      @(posedge clk); #1;
      if (!started && !pb) started = 1;
      if (started) k++;
      if (ram_wr_rd_en) begin
        wrc++;
        chk({nm, "_wrbus"}, {20'd0, ram_address, ram_data},
            {20'd0, v.addr, v.wd});
      end
      if (dut.drv_q) drc++;
      if (dut.drv_q && !ram_wr_rd_en) begin
        hdc++;
        chk({nm, "_hold"}, {20'd0, ram_address, ram_data},
            {20'd0, v.addr, v.wd});
      end
      if (v.c ? ack0 : ack1) other = 1;
      if (v.c ? ack1 : ack0) got = 1;
    end
    if (v.c) req1 = 0; else req0 = 0;
    if (!got) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_lat"}, k, v.lat);
      chk({nm, "_err"}, v.c ? err1 : err0, v.err);
      chk({nm, "_rdata"}, v.c ? rdata1 : rdata0, v.rd);
      chk({nm, "_other_ack"}, other, 0);
      chk({nm, "_wr_cycles"}, wrc,
          (v.we && !v.err) ? 2 : 0);
      chk({nm, "_drv_cycles"}, drc,
          (v.we && !v.err) ? 3 : 0);
      chk({nm, "_hold_cycles"}, hdc,
          (v.we && !v.err) ? 1 : 0);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"},
        {ack0, ack1, err0, err1, busy, ram_wr_rd_en, dut.drv_q},
        7'd0);
    chk({nm, "_addr"}, ram_address, 4'h0);
    chk({nm, "_rdata"}, {rdata0, rdata1}, 16'h0);
  endtask

  initial begin
    vec_t w3, r3;
    int   order [4];
    int   n, extra;

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    tv[0] = '{1'b0, 1'b1, 4'hA, 8'h0F, 5, 1'b0, 8'h00};
    tv[1] = '{1'b1, 1'b1, 4'hB, 8'hF0, 5, 1'b0, 8'h00};
    tv[2] = '{1'b0, 1'b0, 4'hA, 8'h00, 4, 1'b0, 8'h0F};
    tv[3] = '{1'b1, 1'b0, 4'hB, 8'h00, 4, 1'b0, 8'hF0};
    tv[4] = '{1'b0, 1'b0, 4'hF, 8'h00, 1, 1'b1, 8'h0F};
    tv[5] = '{1'b1, 1'b0, 4'hC, 8'h00, 1, 1'b1, 8'hF0};
    tv[6] = '{1'b1, 1'b1, 4'h0, 8'h5A, 5, 1'b0, 8'hF0};
    tv[7] = '{1'b0, 1'b1, 4'h1, 8'hAA, 5, 1'b0, 8'h0F};
    tv[8] = '{1'b0, 1'b0, 4'h1, 8'h00, 4, 1'b0, 8'hAA};
    tv[9] = '{1'b1, 1'b0, 4'h0, 8'h00, 4, 1'b0, 8'h5A};

    repeat (3) @(negedge clk);
    chk_reset("reset_async");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("reset_idle");

    for (int i = 0; i < 10; i++)
      run(tv[i], $sformatf("vec%0d", i));

    // Reset in the middle of a write.
    repeat (3) @(negedge clk);
    rd_phase = 0;
    req0 = 1; we0 = 1; addr0 = 4'h5; wdata0 = 8'h77;
    @(posedge clk);
    @(posedge clk); #3;
    chk("midwr_pre", ram_wr_rd_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset("midwr_rst");
    req0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    w3 = '{1'b0, 1'b1, 4'h3, 8'h33, 5, 1'b0, 8'h00};
    r3 = '{1'b0, 1'b0, 4'h3, 8'h00, 4, 1'b0, 8'h33};
    run(w3, "postrst_wr");
    run(r3, "postrst_rd");

    // Both requesters held: grants must alternate starting at 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_phase = 1;
    we0 = 0; we1 = 0; addr0 = 4'hA; addr1 = 4'hA;
    req0 = 1; req1 = 1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(posedge clk); #1;
      if (ack0 && ack1) chk("rr_dual_ack", 1, 0);
      if (ack0 || ack1) begin
        order[n] = ack1 ? 1 : 0;
        chk($sformatf("rr_rdata%0d", n),
            ack1 ? rdata1 : rdata0, 8'h0F);
        n++;
      end
    end
    req0 = 0; req1 = 0;
    chk("rr_count", n, 4);
    if (n == 4) begin
      chk("rr_order", {order[0][0], order[1][0],
                       order[2][0], order[3][0]}, 4'b0101);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) extra++;
    end
    chk("rr_extra_ack", extra, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
